// File: rtl/multi_channel_watchdog.sv
// Multi-channel watchdog timer.
// Each channel supervises one heartbeat source: it warns after WARN_CYCLES
// idle cycles and trips after TIMEOUT idle cycles. A trip is sticky until the
// channel's clear pulse. Any new trip launches (or extends) a RST_PULSE-cycle
// reset request for the system reset sequencer.
// Optional build macro WD_TRIP_COUNT_EN adds saturating per-channel trip counters.
// state_dbg exposes every channel FSM state, 2 bits per channel at [2i+1:2i]:
// 0 = DISABLED, 1 = ARMED, 2 = WARN, 3 = TRIPPED.
module multi_channel_watchdog #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 100000000,
    parameter int WARN_CYCLES = 75000000,
    parameter int RST_PULSE   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     enable,
    input  logic [NUM_CH-1:0]     heartbeat,
    input  logic [NUM_CH-1:0]     clear,
    input  logic                  force_reset,
    output logic [NUM_CH-1:0]     warning,
    output logic [NUM_CH-1:0]     triggered,
    output logic                  any_triggered,
    output logic                  reset_req,
    output logic [2*NUM_CH-1:0]   state_dbg
`ifdef WD_TRIP_COUNT_EN
    ,
    output logic [8*NUM_CH-1:0]   trip_count
`endif
);

    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_WARN     = 2'd2;
    localparam logic [1:0] ST_TRIPPED  = 2'd3;

    localparam int PULSE_W = $clog2(RST_PULSE + 1);

    localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   WARN_C    = CNT_W'(WARN_CYCLES);
    localparam logic [PULSE_W-1:0] PULSE_C   = PULSE_W'(RST_PULSE);

    // Reject parameter sets that cannot produce a warning before the trip,
    // would need a counter wider than CNT_W, or would never request a reset.
    generate
        if (WARN_CYCLES >= TIMEOUT) begin : g_bad_warn
            $fatal(1, "multi_channel_watchdog: WARN_CYCLES must be below TIMEOUT");
        end
        if (CNT_W < 64 && 64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
            $fatal(1, "multi_channel_watchdog: TIMEOUT does not fit in CNT_W bits");
        end
        if (RST_PULSE == 0) begin : g_bad_pulse
            $fatal(1, "multi_channel_watchdog: RST_PULSE must be at least 1");
        end
    endgenerate

    logic [1:0]         state_q [NUM_CH];
    logic [1:0]         state_d [NUM_CH];
    logic [CNT_W-1:0]   cnt_q   [NUM_CH];
    logic [CNT_W-1:0]   cnt_d   [NUM_CH];
    logic [CNT_W-1:0]   cnt_inc [NUM_CH];
    logic [NUM_CH-1:0]  trip_d;
    logic [NUM_CH-1:0]  trig_prev;
    logic [PULSE_W-1:0] pulse_q;

    // Per-channel next state: force > clear > heartbeat > timeout > enable drop.
    always_comb begin
        trip_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            cnt_inc[i] = cnt_q[i] + CNT_W'(1);
            if (force_reset && (enable[i] || state_q[i] == ST_TRIPPED)) begin
                // Counter is frozen once tripped.
                state_d[i] = ST_TRIPPED;
            end else begin
                case (state_q[i])
                    ST_DISABLED: begin
                        cnt_d[i] = '0;
                        if (enable[i]) begin
                            state_d[i] = ST_ARMED;
                        end
                    end
                    ST_ARMED, ST_WARN: begin
                        if (heartbeat[i]) begin
                            state_d[i] = ST_ARMED;
                            cnt_d[i]   = '0;
                        end else if (cnt_inc[i] == TIMEOUT_C) begin
                            state_d[i] = ST_TRIPPED;
                        end else if (!enable[i]) begin
                            state_d[i] = ST_DISABLED;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_inc[i];
                            if (cnt_inc[i] == WARN_C) begin
                                state_d[i] = ST_WARN;
                            end
                        end
                    end
                    default: begin
                        // TRIPPED ignores heartbeat and enable; only clear leaves.
                        if (clear[i]) begin
                            state_d[i] = enable[i] ? ST_ARMED : ST_DISABLED;
                            cnt_d[i]   = '0;
                        end
                    end
                endcase
            end
            trip_d[i] = (state_d[i] == ST_TRIPPED);
        end
    end

    // Channel state and counter registers, plus the registered trip OR.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_DISABLED;
                cnt_q[i]   <= '0;
            end
            any_triggered <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            any_triggered <= |trip_d;
        end
    end

    // Output decode straight from the state registers.
    always_comb begin
        warning   = '0;
        triggered = '0;
        state_dbg = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            warning[i]            = (state_q[i] == ST_WARN);
            triggered[i]          = (state_q[i] == ST_TRIPPED);
            state_dbg[2*i +: 2]   = state_q[i];
        end
    end

    // Reset request stretcher: reload on any new trip, count down otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_prev <= '0;
            pulse_q   <= '0;
        end else begin
            trig_prev <= triggered;
            if (|(triggered & ~trig_prev)) begin
                pulse_q <= PULSE_C;
            end else if (pulse_q != '0) begin
                pulse_q <= pulse_q - PULSE_W'(1);
            end
        end
    end

    assign reset_req = (pulse_q != '0);

`ifdef WD_TRIP_COUNT_EN
    logic [7:0] tc_q [NUM_CH];

    // Saturating count of entries into TRIPPED; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (trip_d[i] && state_q[i] != ST_TRIPPED && tc_q[i] != 8'hFF) begin
                    tc_q[i] <= tc_q[i] + 8'd1;
                end
            end
        end
    end

    // Pack the per-channel counters onto the output bus.
    always_comb begin
        trip_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            trip_count[8*i +: 8] = tc_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Bench for multi_channel_watchdog with NUM_CH=2, TIMEOUT=8, WARN_CYCLES=6,
// RST_PULSE=4. Directed scenarios followed by random traffic; every cycle is
// compared against an idle-time/trip-history reference model.
module tb_multi_channel_watchdog;

    localparam int NUM_CH      = 2;
    localparam int CNT_W       = 8;
    localparam int TIMEOUT     = 8;
    localparam int WARN_CYCLES = 6;
    localparam int RST_PULSE   = 4;

    logic                clk;
    logic                rst;
    logic [NUM_CH-1:0]   enable;
    logic [NUM_CH-1:0]   heartbeat;
    logic [NUM_CH-1:0]   clear;
    logic                force_reset;
    logic [NUM_CH-1:0]   warning;
    logic [NUM_CH-1:0]   triggered;
    logic                any_triggered;
    logic                reset_req;
    logic [2*NUM_CH-1:0] state_dbg;
`ifdef WD_TRIP_COUNT_EN
    logic [8*NUM_CH-1:0] trip_count;
`endif

    multi_channel_watchdog #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .WARN_CYCLES (WARN_CYCLES),
        .RST_PULSE   (RST_PULSE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .heartbeat     (heartbeat),
        .clear         (clear),
        .force_reset   (force_reset),
        .warning       (warning),
        .triggered     (triggered),
        .any_triggered (any_triggered),
        .reset_req     (reset_req),
        .state_dbg     (state_dbg)
`ifdef WD_TRIP_COUNT_EN
        ,
        .trip_count    (trip_count)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per channel, whether it is supervising, whether it
    // is tripped, how many edges since the last kick/arm, and trip history.
    bit m_trip   [NUM_CH];
    bit m_active [NUM_CH];
    int m_since  [NUM_CH];
    int m_tc     [NUM_CH];
    int edge_no;
    int rise_q[$];

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_trip[i]   = 1'b0;
            m_active[i] = 1'b0;
            m_since[i]  = 0;
            m_tc[i]     = 0;
        end
        edge_no = 0;
        rise_q.delete();
    endfunction

    function automatic void model_step();
        bit rose;
        bit was;
        rose = 1'b0;
        edge_no++;
        for (int i = 0; i < NUM_CH; i++) begin
            was = m_trip[i];
            if (force_reset && (enable[i] || m_trip[i])) begin
                m_trip[i] = 1'b1;
            end else if (m_trip[i]) begin
                if (clear[i]) begin
                    m_trip[i]   = 1'b0;
                    m_active[i] = enable[i];
                    m_since[i]  = 0;
                end
            end else if (!m_active[i]) begin
                if (enable[i]) begin
                    m_active[i] = 1'b1;
                    m_since[i]  = 0;
                end
            end else if (heartbeat[i]) begin
                m_since[i] = 0;
            end else if (m_since[i] + 1 >= TIMEOUT) begin
                m_trip[i] = 1'b1;
            end else if (!enable[i]) begin
                m_active[i] = 1'b0;
                m_since[i]  = 0;
            end else begin
                m_since[i]++;
            end
            if (m_trip[i] && !was) begin
                rose = 1'b1;
                if (m_tc[i] < 255) m_tc[i]++;
            end
        end
        if (rose) begin
            rise_q.push_back(edge_no);
            if (rise_q.size() > 2) void'(rise_q.pop_front());
        end
    endfunction

    function automatic logic [NUM_CH-1:0] exp_warn();
        logic [NUM_CH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++)
            r[i] = !m_trip[i] && m_active[i] && (m_since[i] >= WARN_CYCLES);
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_trig();
        logic [NUM_CH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) r[i] = m_trip[i];
        return r;
    endfunction

    function automatic logic [2*NUM_CH-1:0] exp_state();
        logic [2*NUM_CH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_trip[i])                       r[2*i +: 2] = 2'd3;
            else if (!m_active[i])               r[2*i +: 2] = 2'd0;
            else if (m_since[i] >= WARN_CYCLES)  r[2*i +: 2] = 2'd2;
            else                                 r[2*i +: 2] = 2'd1;
        end
        return r;
    endfunction

    // The request is high on the RST_PULSE edges following any trip rise.
    function automatic logic exp_req();
        logic r;
        r = 1'b0;
        foreach (rise_q[k])
            if (edge_no > rise_q[k] && edge_no <= rise_q[k] + RST_PULSE) r = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("warning",       32'(warning),       32'(exp_warn()));
        chk("triggered",     32'(triggered),     32'(exp_trig()));
        chk("any_triggered", 32'(any_triggered), 32'(|exp_trig()));
        chk("reset_req",     32'(reset_req),     32'(exp_req()));
        chk("state_dbg",     32'(state_dbg),     32'(exp_state()));
`ifdef WD_TRIP_COUNT_EN
        begin
            logic [8*NUM_CH-1:0] e;
            for (int i = 0; i < NUM_CH; i++) e[8*i +: 8] = 8'(m_tc[i]);
            chk("trip_count", 32'(trip_count), 32'(e));
        end
`endif
    endtask

    // Driver tasks
    task automatic step(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] hb,
                        input logic [NUM_CH-1:0] clr, input logic frc);
        enable      = en;
        heartbeat   = hb;
        clear       = clr;
        force_reset = frc;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        enable      = '0;
        heartbeat   = '0;
        clear       = '0;
        force_reset = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        logic [NUM_CH-1:0] r_en, r_hb, r_clr;
        logic              r_frc;
        rst = 1'b1;
        enable = '0; heartbeat = '0; clear = '0; force_reset = 1'b0;
        model_reset();

        // 1: free-running both channels: warn at 6, trip at 8, 4-cycle pulse.
        do_reset();
        do_reset();
        chk("rst_trig", 32'(triggered), 32'(0));
        chk("rst_req",  32'(reset_req), 32'(0));
        step(2'b11, 2'b00, 2'b00, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            step(2'b11, 2'b00, 2'b00, 1'b0);
            if (k == 5)  chk("t1_warn5",  32'(warning),   32'(0));
            if (k == 6)  chk("t1_warn6",  32'(warning),   32'(3));
            if (k == 7)  chk("t1_trig7",  32'(triggered), 32'(0));
            if (k == 8)  chk("t1_trig8",  32'(triggered), 32'(3));
            if (k == 8)  chk("t1_warn8",  32'(warning),   32'(0));
            if (k == 8)  chk("t1_req8",   32'(reset_req), 32'(0));
            if (k >= 9 && k <= 12) chk("t1_req_on", 32'(reset_req), 32'(1));
            if (k == 13) chk("t1_req13",  32'(reset_req), 32'(0));
        end

        // 2: regular kicks every 5 cycles keep channel 0 quiet.
        step(2'b01, 2'b00, 2'b11, 1'b0);
        for (int k = 0; k < 50; k++) begin
            step(2'b01, (k % 5 == 4) ? 2'b01 : 2'b00, 2'b00, 1'b0);
            chk("t2_quiet", 32'({warning[0], triggered[0], reset_req}), 32'(0));
        end

        // 3: kick on exactly the timeout edge wins and drops the warning.
        for (int k = 1; k <= 7; k++) step(2'b01, 2'b00, 2'b00, 1'b0);
        chk("t3_warn_pre", 32'(warning[0]), 32'(1));
        step(2'b01, 2'b01, 2'b00, 1'b0);
        chk("t3_no_trip", 32'(triggered[0]), 32'(0));
        chk("t3_warn_drop", 32'(warning[0]), 32'(0));
        for (int k = 1; k <= 6; k++) begin
            step(2'b01, 2'b00, 2'b00, 1'b0);
            if (k == 5) chk("t3_cnt0_a", 32'(warning[0]), 32'(0));
            if (k == 6) chk("t3_cnt0_b", 32'(warning[0]), 32'(1));
        end

        // 4: trip, clear, re-trip 8 edges later; clear loses to force.
        step(2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b01, 2'b00, 2'b00, 1'b0);
        chk("t4_trip", 32'(triggered[0]), 32'(1));
        for (int k = 0; k < 6; k++) step(2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b01, 2'b00, 2'b01, 1'b0);
        chk("t4_cleared", 32'(triggered[0]), 32'(0));
        for (int k = 1; k <= 8; k++) begin
            step(2'b01, 2'b00, 2'b00, 1'b0);
            if (k == 7) chk("t4_retrip7", 32'(triggered[0]), 32'(0));
            if (k == 8) chk("t4_retrip8", 32'(triggered[0]), 32'(1));
        end
        step(2'b01, 2'b00, 2'b01, 1'b1);
        chk("t4_clr_vs_force", 32'(triggered[0]), 32'(1));

        // 5: force with only ch0 enabled, then ch1 forced mid-pulse.
        for (int k = 0; k < 6; k++) step(2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b01, 2'b00, 2'b11, 1'b0);
        step(2'b01, 2'b00, 2'b00, 1'b1);
        chk("t5_force", 32'(triggered), 32'(1));
        chk("t5_ch1_disabled", 32'(state_dbg[3:2]), 32'(0));
        step(2'b01, 2'b00, 2'b00, 1'b0);
        chk("t5_req_start", 32'(reset_req), 32'(1));
        step(2'b11, 2'b00, 2'b00, 1'b1);
        chk("t5_ch1_trip", 32'(triggered), 32'(3));
        for (int k = 1; k <= 5; k++) begin
            step(2'b11, 2'b00, 2'b00, 1'b0);
            if (k <= 4) chk("t5_req_ext", 32'(reset_req), 32'(1));
            if (k == 5) chk("t5_req_end", 32'(reset_req), 32'(0));
        end

        // 6: rst while ch1 is warning and the pulse is running.
        do_reset();
        step(2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b01, 2'b00, 2'b00, 1'b0);
        for (int k = 2; k <= 9; k++) step(2'b11, 2'b00, 2'b00, 1'b0);
        chk("t6_warn1", 32'(warning[1]), 32'(1));
        chk("t6_req",   32'(reset_req),  32'(1));
        do_reset();
        chk("t6_rst_outs", 32'({warning, triggered, any_triggered, reset_req}), 32'(0));

`ifdef WD_TRIP_COUNT_EN
        step(2'b01, 2'b00, 2'b00, 1'b0);
        for (int k = 0; k < 300; k++) begin
            step(2'b01, 2'b00, 2'b00, 1'b1);
            step(2'b01, 2'b00, 2'b01, 1'b0);
        end
        chk("t6_tc_sat", 32'(trip_count[7:0]), 32'(255));
        do_reset();
        chk("t6_tc_rst", 32'(trip_count), 32'(0));
`endif

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(149) == 0) begin
                do_reset();
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_en[i]  = ($urandom_range(7) != 0);
                    r_hb[i]  = ($urandom_range(5) == 0);
                    r_clr[i] = ($urandom_range(9) == 0);
                end
                r_frc = ($urandom_range(49) == 0);
                step(r_en, r_hb, r_clr, r_frc);
            end
        end

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
